// File: rtl/mult_result_buf_pkg.sv
// Shared types for the multiplier result buffer: the FU result packet and the default depth.
`timescale 1ns/1ps
package mult_result_buf_pkg;

    localparam int MULT_BUF_DEPTH = 4;
    localparam int XLEN           = 32;
    localparam int TAG_W          = 6;
    localparam int ROB_W          = 5;

    typedef struct packed {
        logic [XLEN-1:0]  alu_result;
        logic [TAG_W-1:0] dest_tag;
        logic [ROB_W-1:0] rob_idx;
    } FU_PACKET;

endpackage

// File: rtl/mult_result_buf.sv
// In-order holding buffer between the multiplier and the CDB arbiter; stalls the
// multiplier when full and drops everything on a squash.
`timescale 1ns/1ps
module mult_result_buf
    import mult_result_buf_pkg::*;
#(
    parameter  int DEPTH = MULT_BUF_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  FU_PACKET         in_pack,
    input  logic             cdb_grant,
    input  logic             squash,
    output logic             out_valid,
    output FU_PACKET         out_pack,
    output logic             stall,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);
    localparam int PTR_W = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mult_result_buf: DEPTH must be a power of two >= 2");
    end

    FU_PACKET         entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             full;
    logic             pop;
    logic             push;

    // stall comes only from the count register, so grant never reaches it.
    assign full      = (count == CNT_W'(DEPTH));
    assign stall     = full;
    assign out_valid = (count != '0);
    assign out_pack  = out_valid ? entries[head] : '0;
    assign pop       = out_valid & cdb_grant;
    assign push      = in_valid & ~squash & (~full | pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else begin
            if (in_valid && full && !pop && !squash) overflow <= 1'b1;
            if (squash) begin
                // Stale entry contents are harmless: out_pack is masked when empty.
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    entries[tail] <= in_pack;
                    tail          <= tail + PTR_W'(1);
                end
                if (pop) head <= head + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (reset) begin
            assert (!(in_valid && full && !pop && !squash))
                else $warning("mult_result_buf: in_pack dropped while buffer full");
        end
    end
`endif

endmodule

// File: tb/tb_mult_result_buf.sv
// Scenario bench for mult_result_buf at DEPTH=4 with an expected/observed packet scoreboard.
`timescale 1ns/1ps
module tb_mult_result_buf;
    import mult_result_buf_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clock;
    logic             reset;
    logic             in_valid;
    FU_PACKET         in_pack;
    logic             cdb_grant;
    logic             squash;
    logic             out_valid;
    FU_PACKET         out_pack;
    logic             stall;
    logic [CNT_W-1:0] count;
    logic             overflow;

    int errors = 0;
    int checks = 0;

    FU_PACKET exp_q[$];
    FU_PACKET got_q[$];
    FU_PACKET g;
    FU_PACKET e;

    mult_result_buf #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_pack   (in_pack),
        .cdb_grant (cdb_grant),
        .squash    (squash),
        .out_valid (out_valid),
        .out_pack  (out_pack),
        .stall     (stall),
        .count     (count),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic FU_PACKET mk(input logic [31:0] d);
        FU_PACKET p;
        p            = '0;
        p.alu_result = d;
        p.dest_tag   = d[5:0];
        p.rob_idx    = d[8:4];
        return p;
    endfunction

    // Drives one cycle of inputs and records any packet the arbiter takes.
    task automatic tick(input logic v, input logic [31:0] d, input logic gr, input logic sq);
        in_valid  = v;
        in_pack   = mk(d);
        cdb_grant = gr;
        squash    = sq;
        #1;
        if (out_valid && cdb_grant) got_q.push_back(out_pack);
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        in_pack   = '0;
        cdb_grant = 1'b0;
        squash    = 1'b0;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_pack   = '0;
        cdb_grant = 1'b0;
        squash    = 1'b0;
        reset     = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        in_valid = 1'b1;
        in_pack  = mk(32'hdead);
        @(posedge clock);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_pack !== FU_PACKET'('0)) begin errors++; $display("FAIL reset_out_pack got=%h exp=0", out_pack); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        in_valid = 1'b0;
        reset    = 1'b1;
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_push_kept got=%0d exp=0", count); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 32'h11 * (i + 1), 1'b0, 1'b0);
            exp_q.push_back(mk(32'h11 * (i + 1)));
        end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL fill_count got=%0d exp=3", count); end
        checks++; if (out_pack.alu_result !== 32'h11) begin errors++; $display("FAIL fill_head got=%h exp=11", out_pack.alu_result); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fill_stall got=%b exp=0", stall); end
        repeat (3) tick(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid got=%b exp=0", out_valid); end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL empty_grant_count got=%0d exp=0", count); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL fill_pop_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL fill_order got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 32'hA0 + i, 1'b0, 1'b0);
            exp_q.push_back(mk(32'hA0 + i));
        end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall got=%b exp=1", stall); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_overflow_early got=%b exp=0", overflow); end
        tick(1'b1, 32'h99, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got=%b exp=1", overflow); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL overflow_count got=%0d exp=4", count); end
        checks++; if (out_pack.alu_result !== 32'hA0) begin errors++; $display("FAIL overflow_head got=%h exp=a0", out_pack.alu_result); end
        repeat (4) tick(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL overflow_drain_valid got=%b exp=0", out_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got=%b exp=1", overflow); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL overflow_pop_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL overflow_order got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 32'h30 + i, 1'b0, 1'b0);
            exp_q.push_back(mk(32'h30 + i));
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 32'h44 + i, 1'b1, 1'b0);
            exp_q.push_back(mk(32'h44 + i));
            checks++; if (count !== 3'd2) begin errors++; $display("FAIL wrap_count step=%0d got=%0d exp=2", i, count); end
        end
        repeat (2) tick(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL wrap_pop_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL wrap_order got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_back_to_back_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 32'hB0 + i, 1'b0, 1'b0);
            exp_q.push_back(mk(32'hB0 + i));
        end
        in_valid = 1'b1; cdb_grant = 1'b1; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_pop_stall_same_cycle got=%b exp=1", stall); end
        tick(1'b1, 32'hB4, 1'b1, 1'b0);
        exp_q.push_back(mk(32'hB4));
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_pushpop_count got=%0d exp=4", count); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_pushpop_stall got=%b exp=1", stall); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_pushpop_overflow got=%b exp=0", overflow); end
        checks++; if (out_pack.alu_result !== 32'hB1) begin errors++; $display("FAIL full_pushpop_head got=%h exp=b1", out_pack.alu_result); end
        repeat (4) tick(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL full_pushpop_pop_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL full_pushpop_order got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_squash();
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, 32'hC0 + i, 1'b0, 1'b0);
        // Only the entry granted in the squash cycle leaves; the rest are flushed.
        exp_q.push_back(mk(32'hC0));
        tick(1'b1, 32'h77, 1'b1, 1'b1);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL squash_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL squash_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_pack !== FU_PACKET'('0)) begin errors++; $display("FAIL squash_out_pack got=%h exp=0", out_pack); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL squash_overflow got=%b exp=0", overflow); end
        tick(1'b1, 32'h55, 1'b0, 1'b0);
        exp_q.push_back(mk(32'h55));
        checks++; if (out_pack.alu_result !== 32'h55) begin errors++; $display("FAIL squash_next_head got=%h exp=55", out_pack.alu_result); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL squash_next_count got=%0d exp=1", count); end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL squash_pop_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL squash_order got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 32'hD0 + i, 1'b0, 1'b0);
            if (i < 2) exp_q.push_back(mk(32'hD0 + i));
        end
        tick(1'b1, 32'hD9, 1'b0, 1'b0);
        repeat (2) tick(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (count !== 3'd2 || overflow !== 1'b1) begin errors++; $display("FAIL async_precond count=%0d ovf=%b exp=2/1", count, overflow); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_pack !== FU_PACKET'('0)) begin errors++; $display("FAIL async_out_pack got=%h exp=0", out_pack); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL async_count got=%0d exp=0", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL async_overflow got=%b exp=0", overflow); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL async_stall got=%b exp=0", stall); end
        @(posedge clock);
        #1;
        reset = 1'b1;
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL async_pop_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL async_order got=%h exp=%h", g, e); end
        end
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_pack   = '0;
        cdb_grant = 1'b0;
        squash    = 1'b0;
        #1;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_wrap();
        test_back_to_back_full();
        test_squash();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
